// File: rtl/wdt_reset_ctrl.sv
// Watchdog expiry response controller: warning interrupt with grace window, then a
// fixed-length system reset pulse, plus sticky reset-cause and saturating expiry count.
module wdt_reset_ctrl #(
  parameter int RST_PULSE_LEN = 16,
  parameter int GRACE_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               timeout,
  input  logic               kick,
  input  logic               irq_ack,
  input  logic               clear_cause,
  input  logic [GRACE_W-1:0] grace_cycles,
  output logic               timer_start,
  output logic               wdt_irq,
  output logic               sys_reset_out,
  output logic               reset_cause,
  output logic [7:0]         expiry_count,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    WARN      = 3'd2,
    RST_PULSE = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  localparam logic [15:0]        PULSE_LOAD = 16'(RST_PULSE_LEN - 1);
  localparam logic [GRACE_W-1:0] GRACE_ONE  = GRACE_W'(1);

  state_t             cur_state;
  state_t             nxt_state;
  logic               timeout_q;
  logic               tmo_rise;
  logic [GRACE_W-1:0] grace_cnt;
  logic [GRACE_W-1:0] nxt_grace;
  logic [15:0]        pulse_cnt;
  logic [15:0]        nxt_pulse;
  logic               nxt_start;
  logic               nxt_irq;
  logic               pulse_entry;

  assign tmo_rise    = timeout & ~timeout_q;
  assign pulse_entry = (nxt_state == RST_PULSE) && (cur_state != RST_PULSE);
  assign state       = cur_state;

  // Next-state and next-output decode; registered outputs follow the state they enter.
  always_comb begin
    nxt_state = cur_state;
    nxt_start = 1'b0;
    nxt_irq   = wdt_irq;
    nxt_grace = grace_cnt;
    nxt_pulse = pulse_cnt;
    case (cur_state)
      IDLE: begin
        nxt_irq = 1'b0;
        if (enable) begin
          nxt_state = ARMED;
        end else begin
          nxt_start = 1'b1;
        end
      end
      ARMED: begin
        if (!enable) begin
          nxt_state = IDLE;
          nxt_start = 1'b1;
          nxt_irq   = 1'b0;
        end else if (kick) begin
          nxt_start = 1'b1;
        end else if (tmo_rise) begin
          nxt_start = 1'b1;
          if (grace_cycles != '0) begin
            nxt_state = WARN;
            nxt_irq   = 1'b1;
            nxt_grace = grace_cycles;
          end else begin
            nxt_state = RST_PULSE;
            nxt_pulse = PULSE_LOAD;
          end
        end else begin
          nxt_start = 1'b0;
        end
      end
      WARN: begin
        nxt_grace = grace_cnt - GRACE_ONE;
        if (!enable) begin
          nxt_state = IDLE;
          nxt_start = 1'b1;
          nxt_irq   = 1'b0;
        end else if (kick) begin
          nxt_state = ARMED;
          nxt_start = 1'b1;
          nxt_irq   = 1'b0;
        end else if (grace_cnt <= GRACE_ONE) begin
          // Grace window spent: WARN has lasted exactly grace_cycles cycles.
          nxt_state = RST_PULSE;
          nxt_start = 1'b1;
          nxt_irq   = 1'b0;
          nxt_pulse = PULSE_LOAD;
        end else if (irq_ack) begin
          nxt_irq = 1'b0;
        end else begin
          nxt_irq = wdt_irq;
        end
      end
      RST_PULSE: begin
        nxt_start = 1'b1;
        nxt_irq   = 1'b0;
        if (pulse_cnt == 16'd0) begin
          nxt_state = HOLDOFF;
        end else begin
          nxt_pulse = pulse_cnt - 16'd1;
        end
      end
      HOLDOFF: begin
        nxt_irq = 1'b0;
        if (enable) begin
          nxt_state = ARMED;
        end else begin
          nxt_state = IDLE;
          nxt_start = 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_start = 1'b1;
        nxt_irq   = 1'b0;
      end
    endcase
  end

  // State, counters, registered outputs and diagnostics.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state     <= IDLE;
      timeout_q     <= 1'b0;
      grace_cnt     <= '0;
      pulse_cnt     <= 16'd0;
      timer_start   <= 1'b1;
      wdt_irq       <= 1'b0;
      sys_reset_out <= 1'b0;
      reset_cause   <= 1'b0;
      expiry_count  <= 8'd0;
    end else begin
      cur_state     <= nxt_state;
      timeout_q     <= timeout;
      grace_cnt     <= nxt_grace;
      pulse_cnt     <= nxt_pulse;
      timer_start   <= nxt_start;
      wdt_irq       <= nxt_irq;
      sys_reset_out <= (nxt_state == RST_PULSE);
      if (pulse_entry) begin
        reset_cause <= 1'b1;
      end else if (clear_cause) begin
        reset_cause <= 1'b0;
      end else begin
        reset_cause <= reset_cause;
      end
      if (pulse_entry && (expiry_count != 8'hFF)) begin
        expiry_count <= expiry_count + 8'd1;
      end else begin
        expiry_count <= expiry_count;
      end
    end
  end

endmodule
